// File: rtl/bram_seq_pkg.sv
// bram_seq_pkg: sequencer state encoding, default parameters and skid FIFO entry layout.
package bram_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_RD_LAT = 1;
  // FIFO entry is {word_a, word_b, last} with word_a in the MSBs
  function automatic int entry_w(input int data_w);
    return 2 * data_w + 1;
  endfunction
endpackage

// File: rtl/bram_rd_skid_fifo.sv
// bram_rd_skid_fifo: first-word-fall-through skid buffer with occupancy count and sync flush.
module bram_rd_skid_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 33,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  assign count_o = cnt_q;
  // an empty FIFO presents zeros so the stream reads as reset
  assign dout_o = (cnt_q == '0) ? '0 : mem_q[rp_q];
  always_ff @(posedge clk)
    if (push_i) mem_q[wp_q] <= din_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
      if (pop_i) rp_q <= (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
endmodule

// File: rtl/bram_read_sequencer.sv
// bram_read_sequencer: lockstep A/B BRAM address sweep turned into a ready/valid pair stream.
// Define BRAM_SEQ_CONT_EN to add the cont input for gapless back-to-back passes.
module bram_read_sequencer
  import bram_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
`ifdef BRAM_SEQ_CONT_EN
  input  logic              cont,
`endif
  output logic              busy,
  output logic              done,
  output logic              ena_A,
  output logic              wea_A,
  output logic [ADDR_W-1:0] addra_A,
  output logic              ena_B,
  output logic              wea_B,
  output logic [ADDR_W-1:0] addra_B,
  input  logic [DATA_W-1:0] douta_A,
  input  logic [DATA_W-1:0] douta_B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_last
);
  localparam int DEPTH = RD_LAT + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int EW    = entry_w(DATA_W);
  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q, idx_q;
  logic [RD_LAT-1:0] vld_q, lst_q;
  logic              done_q;
  logic [CW-1:0]     cnt;
  logic [CW:0]       infl, occ;
  logic [EW-1:0]     head;
  logic              issue, is_last, pop, cont_w;
`ifdef BRAM_SEQ_CONT_EN
  assign cont_w = cont;
`else
  assign cont_w = 1'b0;
`endif
  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) infl = infl + (CW + 1)'(vld_q[i]);
  end
  // credit counts both buffered pairs and reads still in the BRAM pipeline
  assign occ       = (CW + 1)'(cnt) + infl;
  assign issue     = (state_q == RUN) && (occ < (CW + 1)'(DEPTH));
  assign is_last   = (idx_q == len_q - 1'b1);
  assign pop       = out_valid && out_ready;
  assign ena_A     = issue;
  assign ena_B     = issue;
  assign wea_A     = 1'b0;
  assign wea_B     = 1'b0;
  assign addra_A   = base_q + idx_q[ADDR_W-1:0];
  assign addra_B   = addra_A;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = (cnt != '0);
  assign {out_a, out_b, out_last} = head;
  bram_rd_skid_fifo #(.DEPTH(DEPTH), .W(EW), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (vld_q[RD_LAT-1]),
    .din_i   ({douta_A, douta_B, lst_q[RD_LAT-1]}),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (cnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      vld_q   <= '0;
      lst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      vld_q[0] <= issue;
      lst_q[0] <= issue && is_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
      done_q <= (pop && out_last) || (state_q == IDLE && start && len == '0);
      case (state_q)
        IDLE: if (start) begin
          base_q  <= base_addr;
          len_q   <= len;
          idx_q   <= '0;
          state_q <= (len == '0) ? DONE : RUN;
        end
        RUN: if (issue) begin
          idx_q <= is_last ? '0 : idx_q + 1'b1;
          if (is_last && !cont_w) state_q <= DRAIN;
        end
        // leave as the final pair is accepted so done lands one cycle later
        DRAIN: if (infl == '0 && (cnt == '0 || (cnt == CW'(1) && pop))) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
